// File: rtl/branch_predict_unit.sv
// branch_predict_unit
//   Bimodal branch predictor and redirect sequencer for an RV32I pipeline.
//   A direct-mapped table of 2-bit saturating counters predicts taken/target
//   for the fetch PC. The table is trained from EX-stage branch resolution.
//   A misprediction raises a registered one-cycle redirect and squashes the
//   wrong-path EX slot that follows it.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   if_valid, if_pc           fetch lookup request
//   pred_taken, pred_target   combinational prediction for if_pc
//   ex_valid, ex_is_br, ex_pc, ex_taken, ex_target
//                             EX-stage resolution of one instruction
//   ex_pred_taken, ex_pred_target
//                             prediction that travelled with that instruction
//   redirect, redirect_pc     registered flush pulse and correct next PC
//   mispredict_cnt            wrapping count of redirects issued
module branch_predict_unit #(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_valid,
    input  logic [31:0] if_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        ex_valid,
    input  logic        ex_is_br,
    input  logic [31:0] ex_pc,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pred_target,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic [31:0] mispredict_cnt
);

    localparam int TAG_W = 32 - IDX_W - 2;

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] SQUASH = 1'b1;

    function automatic logic [1:0] ctr_inc(input logic [1:0] c);
        return (c == 2'd3) ? 2'd3 : c + 2'd1;
    endfunction

    function automatic logic [1:0] ctr_dec(input logic [1:0] c);
        return (c == 2'd0) ? 2'd0 : c - 2'd1;
    endfunction

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];

    logic [0:0]  state_q, state_d;
    logic        redirect_q, redirect_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;
    logic [31:0] cnt_q, cnt_d;

    // PC bits [1:0] never participate in indexing or tagging.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{if_pc[1:0], ex_pc[1:0]};

    // Fetch-side lookup
    logic [IDX_W-1:0] if_idx;
    logic             if_hit;

    assign if_idx      = if_pc[IDX_W+1:2];
    assign if_hit      = if_valid & valid_q[if_idx] & (tag_q[if_idx] == if_pc[31:IDX_W+2]);
    assign pred_taken  = if_hit & ctr_q[if_idx][1];
    assign pred_target = pred_taken ? target_q[if_idx] : 32'd0;

    // EX-side resolution
    logic [IDX_W-1:0] ex_idx;
    logic [TAG_W-1:0] ex_tag;
    logic             ex_hit, accept, br_mis, mispredict;
    logic             alloc, upd, inval;
    logic [1:0]       ctr_d;
    logic [31:0]      tgt_d;

    assign ex_idx = ex_pc[IDX_W+1:2];
    assign ex_tag = ex_pc[31:IDX_W+2];
    assign ex_hit = valid_q[ex_idx] & (tag_q[ex_idx] == ex_tag);
    assign accept = (state_q == IDLE) & ex_valid;

    // Target only matters when both the prediction and the outcome are taken.
    assign br_mis     = (ex_taken != ex_pred_taken)
                      | (ex_taken & ex_pred_taken & (ex_target != ex_pred_target));
    // A non-branch predicted taken means an aliased entry steered fetch wrong.
    assign mispredict = ex_is_br ? br_mis : ex_pred_taken;

    assign alloc = accept & ex_is_br & ~ex_hit & ex_taken;
    assign upd   = accept & ex_is_br & (ex_hit | ex_taken);
    assign inval = accept & ~ex_is_br & ex_pred_taken & ex_hit;

    always_comb begin
        ctr_d = ctr_q[ex_idx];
        tgt_d = target_q[ex_idx];
        if (ex_hit) begin
            if (ex_taken) begin
                ctr_d = ctr_inc(ctr_q[ex_idx]);
                tgt_d = ex_target;
            end else begin
                ctr_d = ctr_dec(ctr_q[ex_idx]);
            end
        end else begin
            ctr_d = 2'd2;
            tgt_d = ex_target;
        end
    end

    always_comb begin
        state_d       = IDLE;
        redirect_d    = 1'b0;
        redirect_pc_d = redirect_pc_q;
        cnt_d         = cnt_q;
        if (accept & mispredict) begin
            state_d       = SQUASH;
            redirect_d    = 1'b1;
            redirect_pc_d = (ex_taken & ex_is_br) ? ex_target : ex_pc + 32'd4;
            cnt_d         = cnt_q + 32'd1;
        end
    end

    // Control state and valid bits
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            redirect_q    <= 1'b0;
            redirect_pc_q <= 32'd0;
            cnt_q         <= 32'd0;
            valid_q       <= '0;
        end else begin
            state_q       <= state_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
            cnt_q         <= cnt_d;
            if (alloc) begin
                valid_q[ex_idx] <= 1'b1;
            end else if (inval) begin
                valid_q[ex_idx] <= 1'b0;
            end
        end
    end

    // Table payload; meaningless while the valid bit is clear, so not reset.
    always_ff @(posedge clk) begin
        if (upd & ~rst) begin
            ctr_q[ex_idx]    <= ctr_d;
            target_q[ex_idx] <= tgt_d;
            if (alloc) begin
                tag_q[ex_idx] <= ex_tag;
            end
        end
    end

    assign redirect       = redirect_q;
    assign redirect_pc    = redirect_pc_q;
    assign mispredict_cnt = cnt_q;

endmodule
